key_onehot_latch: RTL and testbench
===================================

Name: key_onehot_latch

Overview:
- Upstream front end for the 8-to-3 encoder.
- Synchronises and debounces 8 raw key lines, then latches the most recent accepted press as a registered one-hot vector.
- onehot[i] drives encoder input m_i directly, and the latch guarantees at most one bit is ever high.
- Also provides a press strobe and a simultaneous-press flag for downstream logic.

Parameters:
DEB_CYCLES, 4, consecutive synchronised cycles a key level must differ from its debounced level before it is accepted; legal range 2..255
HOLD, 1, 1 = latched key held until next press or clr; 0 = latched key also dropped on its own debounced release

Ports:
clk  input  1  single system clock, rising edge
rst  input  1  asynchronous, active-high reset
key_raw  input  8  asynchronous raw key levels, bit i = key i, 1 = pressed
clr  input  1  synchronous clear of the latched key
onehot  output  8  registered one-hot latched key (bit i -> encoder m_i), all-zero = none
valid  output  1  registered, equals |onehot
new_key  output  1  one-cycle pulse when onehot is loaded by a press
multi  output  1  one-cycle pulse when more than one key is accepted as pressed in the same cycle

Behaviour:
- Reset (async, active-high): sync flops, debounced levels deb[7:0], counters, onehot, valid, new_key and multi all 0 immediately. Reset mid-debounce discards the partial count.
- Synchroniser: 2-flop per bit, giving s2[i].
- Debounce, per bit:
  - if s2[i]==deb[i], cnt[i] <= 0;
  - else if cnt[i]==DEB_CYCLES-1, deb[i] <= s2[i] and cnt[i] <= 0;
  - else cnt[i] <= cnt[i]+1.
  - Counter width is 8 bits.
  - Any disagreement shorter than DEB_CYCLES synchronised cycles is ignored.
- Press event: press[i] = deb[i] flips 0->1 on this edge (combinational from the debounce next-state).
- Release event: rel[i] = deb[i] flips 1->0 on this edge.
- Latency: key_raw[i] first sampled high at edge E and held -> deb[i], onehot[i], new_key all update at edge E+DEB_CYCLES+1 (E+5 at default).
- Latch update, in priority order each edge:
  1. any press[i]: onehot <= one-hot of the lowest index i with press[i]=1; new_key <= 1; multi <= 1 if popcount(press)>=2, else 0.
  2. else clr=1: onehot <= 0.
  3. else HOLD=0 and rel[j]=1 where onehot[j]=1: onehot <= 0.
  4. else onehot holds.
  - new_key and multi are 0 in every cycle without a press event.
- Boundary rules:
  - Press and clr in the same cycle: the press wins and onehot loads.
  - Press of the already-latched key after its release: reloads the same value and pulses new_key.
  - Release of a non-latched key: no effect.
  - A key held continuously produces exactly one press event.
- Invariant: popcount(onehot) <= 1 at all times; valid == |onehot in every cycle.

Test Plan:
- Reset then idle: rst=1 for 3 cycles, key_raw=8'h00 -> onehot=8'h00, valid=0, new_key=0, multi=0; asserting rst mid-count clears everything asynchronously.
- Single press, default params: key_raw=8'h08 from edge E, held -> onehot=8'h08, valid=1 and new_key=1 for exactly one cycle after edge E+5; the downstream encoder yields s2s1s0=011.
- Glitch reject: key_raw bit 5 high for 3 cycles, then low -> onehot stays 8'h00, no new_key; a 4-cycle pulse is accepted (onehot=8'h20).
- Simultaneous press: key_raw 8'h00 -> 8'h84 in one cycle -> onehot=8'h04, new_key=1, multi=1 on the same cycle; a later press of bit 1 alone -> onehot=8'h02, multi=0.
- Release and clear: with HOLD=1, releasing latched key 8'h10 keeps onehot=8'h10 and clr=1 gives 8'h00; with HOLD=0, release gives onehot=8'h00 at edge release+DEB_CYCLES+1.
- Clr/press collision: clr=1 on the same edge key 6's press is accepted -> onehot=8'h40, new_key=1.

Source files
------------

// File: rtl/key_onehot_latch.sv
// rtl/key_onehot_latch.sv - key synchroniser, debouncer and one-hot press latch
module key_onehot_latch #(
   parameter int DEB_CYCLES = 4,
   parameter bit HOLD       = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] key_raw,
   input  logic       clr,
   output logic [7:0] onehot,
   output logic       valid,
   output logic       new_key,
   output logic       multi
);

   localparam logic [7:0] CNT_LAST = 8'(DEB_CYCLES - 1);

   logic [7:0] s1;
   logic [7:0] s2;
   logic [7:0] deb;
   logic [7:0] deb_next;
   logic [7:0] cnt      [8];
   logic [7:0] cnt_next [8];
   logic [7:0] press;
   logic [7:0] rel;
   logic [7:0] press_low;
   logic       press_multi;
   logic [7:0] onehot_next;

   // two-flop synchroniser for the asynchronous key lines
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1 <= '0;
         s2 <= '0;
      end else begin
         s1 <= key_raw;
         s2 <= s1;
      end
   end

   // per-key debounce: a level must disagree for DEB_CYCLES cycles to be accepted
   always_comb begin
      deb_next = deb;
      for (int i = 0; i < 8; i++) begin
         cnt_next[i] = cnt[i];
         if (s2[i] == deb[i]) begin
            cnt_next[i] = '0;
         end else if (cnt[i] == CNT_LAST) begin
            deb_next[i] = s2[i];
            cnt_next[i] = '0;
         end else begin
            cnt_next[i] = cnt[i] + 8'd1;
         end
      end
   end

   // debounced levels and their disagreement counters
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         deb <= '0;
         for (int i = 0; i < 8; i++) cnt[i] <= '0;
      end else begin
         deb <= deb_next;
         for (int i = 0; i < 8; i++) cnt[i] <= cnt_next[i];
      end
   end

   // edge events and latch next-state; lowest pressed index wins via x & -x
   always_comb begin
      press       = deb_next & ~deb;
      rel         = deb & ~deb_next;
      press_low   = press & (~press + 8'd1);
      press_multi = |(press & (press - 8'd1));
      if (|press) begin
         onehot_next = press_low;
      end else if (clr) begin
         onehot_next = '0;
      end else if (!HOLD && |(rel & onehot)) begin
         onehot_next = '0;
      end else begin
         onehot_next = onehot;
      end
   end

   // registered outputs; strobes only ever fire on a press event
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         onehot  <= '0;
         valid   <= 1'b0;
         new_key <= 1'b0;
         multi   <= 1'b0;
      end else begin
         onehot  <= onehot_next;
         valid   <= |onehot_next;
         new_key <= |press;
         multi   <= press_multi;
      end
   end

endmodule

// File: tb/tb_key_onehot_latch.sv
// tb/tb_key_onehot_latch.sv - directed scoreboard bench for key_onehot_latch
module tb_key_onehot_latch;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] key_raw = 8'h00;
   logic       clr = 1'b0;
   logic [7:0] h1_onehot, h0_onehot;
   logic       h1_valid, h0_valid, h1_new_key, h0_new_key, h1_multi, h0_multi;

   int total  = 0;
   int passed = 0;
   logic inv_en = 1'b0;

   typedef struct {
      string      tag;
      int         sel;
      logic [7:0] oh;
      logic       nk;
      logic       mu;
   } exp_t;
   exp_t sb[$];

   always #5 clk = ~clk;

   key_onehot_latch #(.DEB_CYCLES(4), .HOLD(1'b1)) dut_h1 (
      .clk(clk), .rst(rst), .key_raw(key_raw), .clr(clr),
      .onehot(h1_onehot), .valid(h1_valid), .new_key(h1_new_key), .multi(h1_multi)
   );

   key_onehot_latch #(.DEB_CYCLES(4), .HOLD(1'b0)) dut_h0 (
      .clk(clk), .rst(rst), .key_raw(key_raw), .clr(clr),
      .onehot(h0_onehot), .valid(h0_valid), .new_key(h0_new_key), .multi(h0_multi)
   );

   task automatic cmp(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic push_exp(input string tag, input int sel, input logic [7:0] oh,
                           input logic nk, input logic mu);
      exp_t e;
      e.tag = tag; e.sel = sel; e.oh = oh; e.nk = nk; e.mu = mu;
      sb.push_back(e);
   endtask

   task automatic check_out();
      exp_t e;
      logic [7:0] oh;
      logic v, nk, mu;
      if (sb.size() == 0) begin
         cmp("scoreboard empty", 8'h01, 8'h00);
      end else begin
         e = sb.pop_front();
         if (e.sel == 0) begin
            oh = h1_onehot; v = h1_valid; nk = h1_new_key; mu = h1_multi;
         end else begin
            oh = h0_onehot; v = h0_valid; nk = h0_new_key; mu = h0_multi;
         end
         cmp({e.tag, " onehot"}, oh, e.oh);
         cmp({e.tag, " valid"}, {7'b0, v}, {7'b0, |e.oh});
         cmp({e.tag, " new_key"}, {7'b0, nk}, {7'b0, e.nk});
         cmp({e.tag, " multi"}, {7'b0, mu}, {7'b0, e.mu});
      end
   endtask

   // at most one latched key and valid tracking onehot, every cycle
   always @(negedge clk) begin
      if (inv_en) begin
         cmp("inv h1", {7'b0, ($countones(h1_onehot) <= 1) && (h1_valid == |h1_onehot)}, 8'h01);
         cmp("inv h0", {7'b0, ($countones(h0_onehot) <= 1) && (h0_valid == |h0_onehot)}, 8'h01);
      end
   end

   initial begin
      logic seen;
      // reset then idle
      rst = 1'b1; key_raw = 8'h00; clr = 1'b0;
      tick(3);
      rst = 1'b0;
      push_exp("reset h1", 0, 8'h00, 0, 0);
      push_exp("reset h0", 1, 8'h00, 0, 0);
      check_out(); check_out();
      inv_en = 1'b1;

      // single press of key 3, latency DEB_CYCLES+1 edges
      key_raw = 8'h08;
      push_exp("press3 early", 0, 8'h00, 0, 0);
      push_exp("press3 h1", 0, 8'h08, 1, 0);
      push_exp("press3 h0", 1, 8'h08, 1, 0);
      push_exp("press3 pulse end", 0, 8'h08, 0, 0);
      tick(5); check_out();
      tick(1); check_out(); check_out();
      tick(1); check_out();

      // asynchronous reset between edges, then full relatch
      #2 rst = 1'b1;
      #1 push_exp("async rst h1", 0, 8'h00, 0, 0);
      push_exp("async rst h0", 1, 8'h00, 0, 0);
      check_out(); check_out();
      @(negedge clk) rst = 1'b0;
      push_exp("relatch early", 0, 8'h00, 0, 0);
      push_exp("relatch h1", 0, 8'h08, 1, 0);
      push_exp("relatch h0", 1, 8'h08, 1, 0);
      tick(5); check_out();
      tick(1); check_out(); check_out();
      tick(1);

      // release: HOLD=1 keeps, HOLD=0 drops
      key_raw = 8'h00;
      push_exp("release hold1", 0, 8'h08, 0, 0);
      push_exp("release hold0", 1, 8'h00, 0, 0);
      tick(6); check_out(); check_out();
      tick(2);

      // clear
      clr = 1'b1; tick(1); clr = 1'b0;
      push_exp("clr h1", 0, 8'h00, 0, 0);
      check_out();

      // 3-cycle glitch on key 5 is rejected
      key_raw = 8'h20; tick(3); key_raw = 8'h00;
      seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick(1);
         seen = seen | h1_new_key | (|h1_onehot);
      end
      cmp("glitch no press", {7'b0, seen}, 8'h00);

      // 4-cycle pulse on key 5 is accepted
      key_raw = 8'h20; tick(4); key_raw = 8'h00;
      push_exp("pulse4 h1", 0, 8'h20, 1, 0);
      push_exp("pulse4 h0", 1, 8'h20, 1, 0);
      tick(2); check_out(); check_out();
      push_exp("pulse4 after h1", 0, 8'h20, 0, 0);
      push_exp("pulse4 after h0", 1, 8'h00, 0, 0);
      tick(6); check_out(); check_out();

      // simultaneous press of keys 7 and 2, then key 1 alone
      key_raw = 8'h84;
      push_exp("simul h1", 0, 8'h04, 1, 1);
      push_exp("simul h0", 1, 8'h04, 1, 1);
      tick(6); check_out(); check_out();
      key_raw = 8'h86;
      push_exp("key1 h1", 0, 8'h02, 1, 0);
      push_exp("key1 h0", 1, 8'h02, 1, 0);
      push_exp("key1 pulse end", 0, 8'h02, 0, 0);
      tick(6); check_out(); check_out();
      tick(1); check_out();
      key_raw = 8'h00;
      push_exp("all release h1", 0, 8'h02, 0, 0);
      push_exp("all release h0", 1, 8'h00, 0, 0);
      tick(8); check_out(); check_out();

      // clr on the same edge as key 6 press: press wins
      key_raw = 8'h40;
      tick(5); clr = 1'b1; tick(1); clr = 1'b0;
      push_exp("collide h1", 0, 8'h40, 1, 0);
      push_exp("collide h0", 1, 8'h40, 1, 0);
      push_exp("held single event", 0, 8'h40, 0, 0);
      push_exp("clr after collide", 0, 8'h00, 0, 0);
      check_out(); check_out();
      tick(3); check_out();
      clr = 1'b1; tick(1); clr = 1'b0;
      check_out();
      key_raw = 8'h00; tick(8);

      // same key pressed again after release reloads and pulses
      key_raw = 8'h10;
      push_exp("key4 h1", 0, 8'h10, 1, 0);
      tick(6); check_out();
      key_raw = 8'h00;
      push_exp("key4 held h1", 0, 8'h10, 0, 0);
      push_exp("key4 dropped h0", 1, 8'h00, 0, 0);
      tick(8); check_out(); check_out();
      key_raw = 8'h10;
      push_exp("key4 again h1", 0, 8'h10, 1, 0);
      push_exp("key4 again h0", 1, 8'h10, 1, 0);
      tick(6); check_out(); check_out();

      inv_en = 1'b0;
      cmp("scoreboard drained", 8'(sb.size()), 8'h00);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
